hex_display_ctrl: RTL and testbench
===================================

Name: hex_display_ctrl

Overview:
Parametrised, clocked controller for a bank of 7-segment hex displays. It accepts a multi-nibble value through a valid/ready handshake and shows it statically, blinking, or scrolled across the available digits. It supports leading-zero blanking, per-digit decimal points and selectable segment polarity. It sits between result-producing blocks (ALU, counters) and the board HEX outputs, and replaces per-project combinational digit decoding.

Parameters:
NUM_DIGITS, 6, number of physical digits driven.
VALUE_NIBBLES, 8, nibbles in in_value; must be >= NUM_DIGITS.
TICK_DIV, 25000000, clock cycles per blink/scroll tick (0.5 s at 50 MHz); must be >= 2.
ACTIVE_LOW, 1, 1 = segment lit by driving 0; 0 = lit by 1.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset.
- One clock; reset is asynchronous and active-low.
in_valid  in  1  producer presents value/mode.
in_ready  out  1  controller can accept.
in_value  in  4*VALUE_NIBBLES  value to display; nibble k at [4k+3:4k].
in_mode  in  2  0 = static, 1 = blink, 2 = scroll, 3 = reserved (treated as static).
blank_lz  in  1  leading-zero blanking enable; sampled with in_value.
dp_mask  in  NUM_DIGITS  bit k lights the decimal point of digit k; sampled with in_value.
hex_out  out  8*NUM_DIGITS  digit k at [8k+7:8k], bit order h g f e d c b a (h = dp).
busy  out  1  scroll pass in progress.

Behaviour:
- Reset (async, immediate):
  - State IDLE, all stored fields 0, tick counter 0, blink phase on.
  - hex_out all segments off (all 1s if ACTIVE_LOW, else all 0s).
  - in_ready = 1, busy = 0.
- Transfer occurs on a rising edge with in_valid && in_ready. It captures in_value, in_mode, blank_lz and dp_mask, and clears the tick counter and blink phase.
  - hex_out is registered: the new content appears the cycle after acceptance.
  - While in_ready = 0, in_valid has no effect. The producer holds it; acceptance happens on the first cycle in_ready = 1.
- Tick:
  - Counter runs 0..TICK_DIV-1 in every state except IDLE.
  - tick = counter == TICK_DIV-1; counter wraps to 0.
- States:
  - IDLE: all segments off, in_ready = 1. Any accept goes to SHOW, BLINK or SCROLL by mode.
  - SHOW: window offset 0, so digit k shows nibble k. in_ready = 1. Stays until the next accept.
  - BLINK: same content as SHOW while phase = on. Phase toggles on each tick; off phase blanks all segments including dp. in_ready = 1.
  - SCROLL:
    - Offset starts at VALUE_NIBBLES-NUM_DIGITS, so the most significant window shows first. Digit k shows nibble k+offset.
    - Each tick decrements offset. A tick at offset 0 goes to SHOW.
    - in_ready = 0 and busy = 1 throughout. in_ready rises the same cycle SHOW is entered.
    - If VALUE_NIBBLES == NUM_DIGITS, a scroll request goes directly to SHOW and busy is never asserted.
- Leading-zero blanking, when blank_lz = 1 in SHOW or BLINK:
  - Digits above the most significant nonzero nibble of the window are blanked.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - The dp of a blanked digit still follows dp_mask.
  - Blanking is not applied in SCROLL.
- Glyphs, active-high gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - Bit 7 = dp_mask[k]. With ACTIVE_LOW = 1 the full byte is inverted.
- Bits of in_value above the shown window are ignored outside SCROLL.

Decomposition:
- Package hex_display_pkg:
  - mode enum (MODE_STATIC, MODE_BLINK, MODE_SCROLL).
  - state enum (IDLE, SHOW, BLINK, SCROLL).
  - 16-entry glyph constant array.
- Sub-module seg7_glyph_decoder: combinational nibble + dp + blank + polarity -> 8-bit segment byte, generated NUM_DIGITS times.
- The top holds the FSM, tick counter, offset and capture registers.

Test Plan:
All tests use NUM_DIGITS=4, VALUE_NIBBLES=6, TICK_DIV=4, ACTIVE_LOW=1.
- Reset: rst_n low mid-cycle -> hex_out = 32'hFFFF_FFFF, in_ready = 1 and busy = 0 without waiting for a clock edge.
- Static with blanking: accept 24'h0000A5, mode 0, blank_lz = 1, dp_mask = 0 -> next cycle hex_out = 32'hFFFF_8892. The same value with blank_lz = 0 -> 32'hC0C0_8892.
- Blink: accept 24'h001234, mode 1, blank_lz = 0 -> hex_out = 32'hF9A4_B099. After 4 cycles -> 32'hFFFF_FFFF. After 8 cycles -> 32'hF9A4_B099 again. in_ready stays 1.
- Scroll: accept 24'h123456, mode 2 ->
  - hex_out = 32'hF9A4_B099, busy = 1, in_ready = 0.
  - +4 cycles -> window 2345.
  - +8 cycles -> window 3456.
  - +12 cycles -> SHOW with the same window, in_ready = 1, busy = 0.
  - A held in_valid with 24'h000001 is accepted that cycle.
- Reset mid-scroll: assert rst_n low at offset 1 -> hex_out = 32'hFFFF_FFFF and in_ready = 1 immediately. After release the block stays IDLE until the next accept.
- Decimal point: accept 0, mode 0, blank_lz = 1, dp_mask = 4'b0001 -> hex_out = 32'hFFFF_FF40. With dp_mask = 4'b1000 -> 32'h7FFF_FFC0.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display controller: request modes,
// FSM state codes and the active-high gfedcba glyph table.
package hex_display_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SCROLL = 2'd2
  } mode_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHOW   = 2'd1;
  localparam logic [1:0] ST_BLINK  = 2'd2;
  localparam logic [1:0] ST_SCROLL = 2'd3;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Combinational nibble-to-segment decoder for one digit, with dp, blanking
// and output polarity. Byte order is h g f e d c b a.
module seg7_glyph_decoder
  import hex_display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] lit;

  always_comb begin
    lit = {dp, blank ? 7'h00 : GLYPH[nibble]};
    seg = ACTIVE_LOW ? ~lit : lit;
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Controller for a bank of 7-segment digits: accepts a value over valid/ready
// and shows it statically, blinking, or scrolled across the digits.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 6,
  parameter int unsigned VALUE_NIBBLES = 8,
  parameter int unsigned TICK_DIV      = 25000000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4*VALUE_NIBBLES-1:0] in_value,
  input  logic [1:0]                 in_mode,
  input  logic                       blank_lz,
  input  logic [NUM_DIGITS-1:0]      dp_mask,
  output logic [8*NUM_DIGITS-1:0]    hex_out,
  output logic                       busy
);

  localparam int unsigned SPAN  = VALUE_NIBBLES - NUM_DIGITS;
  localparam int unsigned OFF_W = (SPAN > 0) ? $clog2(SPAN + 1) : 1;
  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [7:0]  SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [1:0]                 state_q, state_d;
  logic [4*VALUE_NIBBLES-1:0] value_q, value_d;
  logic                       blank_lz_q, blank_lz_d;
  logic [NUM_DIGITS-1:0]      dp_q, dp_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       phase_q, phase_d;
  logic [OFF_W-1:0]           offset_q, offset_d;
  logic [8*NUM_DIGITS-1:0]    hex_q, hex_d;

  logic accept, tick;

  assign in_ready = (state_q != ST_SCROLL);
  assign busy     = (state_q == ST_SCROLL);
  assign accept   = in_valid && in_ready;
  assign tick     = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TICK_DIV - 1));
  assign hex_out  = hex_q;

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    blank_lz_d = blank_lz_q;
    dp_d       = dp_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    offset_d   = offset_q;

    if (state_q != ST_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    if (tick && state_q == ST_BLINK) begin
      phase_d = ~phase_q;
    end

    if (tick && state_q == ST_SCROLL) begin
      if (offset_q == '0) begin
        state_d = ST_SHOW;
      end else begin
        offset_d = offset_q - OFF_W'(1);
      end
    end

    if (accept) begin
      value_d    = in_value;
      blank_lz_d = blank_lz;
      dp_d       = dp_mask;
      cnt_d      = '0;
      phase_d    = 1'b1;
      offset_d   = '0;
      case (in_mode)
        MODE_BLINK: state_d = ST_BLINK;
        MODE_SCROLL: begin
          // With no spare nibbles there is nothing to scroll through.
          if (SPAN > 0) begin
            state_d  = ST_SCROLL;
            offset_d = OFF_W'(SPAN);
          end else begin
            state_d = ST_SHOW;
          end
        end
        default: state_d = ST_SHOW;
      endcase
    end
  end

  // The display is decoded from next-state values so the registered output
  // changes on the same edge as the state it reflects.
  logic [NUM_DIGITS-1:0][3:0] nib;
  logic [NUM_DIGITS-1:0]      lz;
  logic                       nz_seen;

  always_comb begin
    nib     = '0;
    lz      = '0;
    nz_seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib[k]  = value_d[4*(k + int'(offset_d)) +: 4];
      nz_seen = nz_seen | (nib[k] != 4'h0);
      lz[k]   = (k != 0) && !nz_seen;
    end
  end

  logic [NUM_DIGITS-1:0] dig_blank, dig_dp;
  logic                  show_on;

  always_comb begin
    dig_blank = '1;
    dig_dp    = '0;
    show_on   = (state_d == ST_SHOW) || (state_d == ST_BLINK && phase_d);
    if (state_d == ST_SCROLL) begin
      dig_blank = '0;
      dig_dp    = dp_d;
    end else if (show_on) begin
      dig_blank = blank_lz_d ? lz : '0;
      dig_dp    = dp_d;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_glyph_decoder #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_dec (
      .nibble(nib[g]),
      .dp    (dig_dp[g]),
      .blank (dig_blank[g]),
      .seg   (hex_d[8*g +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      value_q    <= '0;
      blank_lz_q <= 1'b0;
      dp_q       <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b1;
      offset_q   <= '0;
      hex_q      <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      blank_lz_q <= blank_lz_d;
      dp_q       <= dp_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      offset_q   <= offset_d;
      hex_q      <= hex_d;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: directed cases plus randomized transactions
// checked against a model computed from elapsed cycles since acceptance.
module tb_hex_display_ctrl;

  localparam int ND = 4;
  localparam int VN = 6;
  localparam int TD = 4;

  localparam logic [6:0] GL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_value;
  logic [1:0]  in_mode;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [31:0] hex_out;
  logic        busy;

  always #5 clk = ~clk;

  hex_display_ctrl #(
    .NUM_DIGITS   (ND),
    .VALUE_NIBBLES(VN),
    .TICK_DIV     (TD),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_value(in_value),
    .in_mode (in_mode),
    .blank_lz(blank_lz),
    .dp_mask (dp_mask),
    .hex_out (hex_out),
    .busy    (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Model: the captured request plus the number of edges since it was taken.
  bit          m_active = 1'b0;
  int          m_mode   = 0;
  logic [23:0] m_value  = '0;
  bit          m_blz    = 1'b0;
  logic [3:0]  m_dp     = '0;
  int          m_n      = 0;

  function automatic bit m_scrolling();
    return m_active && m_mode == 2 && m_n < TD * (VN - ND + 1);
  endfunction

  function automatic logic [31:0] exp_hex();
    logic [31:0] r;
    logic [7:0]  b;
    logic [3:0]  nb;
    int          off;
    int          top;
    bit          scr;
    bit          on;
    r   = '1;
    off = 0;
    top = -1;
    scr = m_scrolling();
    on  = 1'b1;
    if (!m_active) return r;
    if (scr) off = (VN - ND) - m_n / TD;
    if (m_mode == 1) on = ((m_n / TD) % 2) == 0;
    if (!on) return r;
    for (int k = 0; k < ND; k++) begin
      nb = 4'((m_value >> (4 * (k + off))) & 24'hF);
      if (nb != 4'h0) top = k;
    end
    for (int k = 0; k < ND; k++) begin
      nb = 4'((m_value >> (4 * (k + off))) & 24'hF);
      b  = {m_dp[k], GL[nb]};
      if (!scr && m_blz && k > top && k != 0) b[6:0] = 7'h00;
      r[8*k +: 8] = ~b;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".hex"}, hex_out, exp_hex());
    chk({tag, ".ready"}, 32'(in_ready), 32'(!m_scrolling()));
    chk({tag, ".busy"}, 32'(busy), 32'(m_scrolling()));
  endtask

  task automatic step();
    bit acc;
    acc = in_valid && !m_scrolling();
    @(posedge clk);
    #1;
    if (acc) begin
      m_active = 1'b1;
      m_value  = in_value;
      m_mode   = (in_mode == 2'd3) ? 0 : int'(in_mode);
      m_blz    = blank_lz;
      m_dp     = dp_mask;
      m_n      = 0;
    end else if (m_active) begin
      m_n++;
    end
  endtask

  task automatic send(input logic [23:0] v, input logic [1:0] md, input bit blz,
                      input logic [3:0] dpm);
    in_value = v;
    in_mode  = md;
    blank_lz = blz;
    dp_mask  = dpm;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    in_mode  = '0;
    blank_lz = 1'b0;
    dp_mask  = '0;

    #3 rst_n = 1'b0;
    #1;
    check_all("reset");
    chk("reset.const", hex_out, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_all("idle");

    send(24'h0000A5, 2'd0, 1'b1, 4'b0000);
    check_all("static_lz");
    chk("static_lz.const", hex_out, 32'hFFFF_8892);
    send(24'h0000A5, 2'd0, 1'b0, 4'b0000);
    chk("static_nolz.const", hex_out, 32'hC0C0_8892);

    send(24'h001234, 2'd1, 1'b0, 4'b0000);
    chk("blink_on.const", hex_out, 32'hF9A4_B099);
    repeat (4) begin step(); check_all("blink"); end
    chk("blink_off.const", hex_out, 32'hFFFF_FFFF);
    repeat (4) begin step(); check_all("blink"); end
    chk("blink_on2.const", hex_out, 32'hF9A4_B099);

    send(24'h123456, 2'd2, 1'b0, 4'b0000);
    check_all("scroll0");
    chk("scroll0.const", hex_out, 32'hF9A4_B099);
    in_value = 24'h000001;
    in_mode  = 2'd0;
    blank_lz = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin step(); check_all("scroll"); end
    chk("scroll1.const", hex_out, 32'hA4B0_9992);
    repeat (4) begin step(); check_all("scroll"); end
    chk("scroll2.const", hex_out, 32'hB099_9282);
    repeat (4) begin step(); check_all("scroll"); end
    chk("scroll_done.const", hex_out, 32'hB099_9282);
    chk("scroll_done.ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_all("held_accept");
    chk("held_accept.const", hex_out, 32'hC0C0_C0F9);

    send(24'h123456, 2'd2, 1'b0, 4'b0000);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    m_active = 1'b0;
    check_all("rst_scroll");
    chk("rst_scroll.const", hex_out, 32'hFFFF_FFFF);
    #1 rst_n = 1'b1;
    repeat (3) begin step(); check_all("post_rst_idle"); end

    send(24'h000000, 2'd0, 1'b1, 4'b0001);
    chk("dp0.const", hex_out, 32'hFFFF_FF40);
    send(24'h000000, 2'd0, 1'b1, 4'b1000);
    chk("dp3.const", hex_out, 32'h7FFF_FFC0);
    check_all("dp3");

    for (int t = 0; t < 40; t++) begin
      for (int w = 0; w < 20 && m_scrolling(); w++) begin
        step();
        check_all("rnd_wait");
      end
      send(24'($urandom) >> (4 * $urandom_range(0, 6)), 2'($urandom), 1'($urandom),
           4'($urandom));
      check_all("rnd_acc");
      repeat ($urandom_range(0, 14)) begin
        step();
        check_all("rnd_run");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
